// File: rtl/mapper_discrete_pkg.sv
// Shared constants for the discrete-logic mapper: mode codes, write FSM states,
// nametable layout codes and a small mode helper.
package mapper_discrete_pkg;

  localparam logic [2:0] MAPPER_MODE_AXROM = 3'd0;
  localparam logic [2:0] MAPPER_MODE_UXROM = 3'd1;
  localparam logic [2:0] MAPPER_MODE_CNROM = 3'd2;
  localparam logic [2:0] MAPPER_MODE_GXROM = 3'd3;
  localparam logic [2:0] MAPPER_MODE_BNROM = 3'd4;
  localparam logic [2:0] MAPPER_MODE_NROM  = 3'd5;

  // Nametable layout codes shared with the PPU nametable mapper.
  localparam logic [2:0] NT_LAYOUT_HORIZONTAL   = 3'd0;
  localparam logic [2:0] NT_LAYOUT_VERTICAL     = 3'd1;
  localparam logic [2:0] NT_LAYOUT_SINGLE_LOWER = 3'd2;
  localparam logic [2:0] NT_LAYOUT_SINGLE_UPPER = 3'd3;
  localparam logic [2:0] NT_LAYOUT_FOUR_SCREEN  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } wr_state_e;

  // Codes 5..7 all behave as NROM.
  function automatic logic is_nrom_mode(input logic [2:0] mode);
    return mode >= MAPPER_MODE_NROM;
  endfunction

endpackage

// File: rtl/mapper_discrete_if.sv
// Bus-conflict ROM read port: request/address from the mapper, same-cycle
// acknowledge and data from the PRG memory controller.
interface mapper_discrete_if #(
  parameter int PRG_ADDR_W = 19
);
  logic                  bc_rd_req_o;
  logic [PRG_ADDR_W-1:0] bc_rd_addr_o;
  logic                  bc_rd_ack_i;
  logic [7:0]            bc_rd_data_i;

  modport master (
    output bc_rd_req_o,
    output bc_rd_addr_o,
    input  bc_rd_ack_i,
    input  bc_rd_data_i
  );

  modport slave (
    input  bc_rd_req_o,
    input  bc_rd_addr_o,
    output bc_rd_ack_i,
    output bc_rd_data_i
  );
endinterface

// File: rtl/mapper_discrete_decode.sv
// Combinational PRG/CHR address and nametable layout composition from mode and
// bank register; no latency, no flow control.
module mapper_discrete_decode
  import mapper_discrete_pkg::*;
#(
  parameter int PRG_ADDR_W = 19,
  parameter int CHR_ADDR_W = 18
) (
  input  logic [2:0]            mode,
  input  logic [7:0]            bank,
  input  logic [7:0]            prg_last_bank,
  input  logic [2:0]            hdr_layout,
  input  logic [14:0]           prg_addr,
  input  logic [12:0]           chr_addr,
  output logic [PRG_ADDR_W-1:0] prg_rom_addr,
  output logic [CHR_ADDR_W-1:0] chr_mem_addr,
  output logic [2:0]            nametable_layout
);

  // No discrete board wires the top two bank bits.
  logic unused_bank;
  assign unused_bank = &{1'b0, bank[7:6]};

  // Casts zero-extend or drop the MSBs of an overflowing bank index.
  always_comb begin
    prg_rom_addr     = PRG_ADDR_W'(prg_addr);
    chr_mem_addr     = CHR_ADDR_W'(chr_addr);
    nametable_layout = hdr_layout;
    case (mode)
      MAPPER_MODE_AXROM: begin
        prg_rom_addr     = PRG_ADDR_W'({bank[2:0], prg_addr});
        nametable_layout = bank[4] ? NT_LAYOUT_SINGLE_UPPER : NT_LAYOUT_SINGLE_LOWER;
      end
      MAPPER_MODE_UXROM: begin
        if (prg_addr[14]) begin
          prg_rom_addr = PRG_ADDR_W'({prg_last_bank, prg_addr[13:0]});
        end else begin
          prg_rom_addr = PRG_ADDR_W'({bank[3:0], prg_addr[13:0]});
        end
      end
      MAPPER_MODE_CNROM: begin
        chr_mem_addr = CHR_ADDR_W'({bank[1:0], chr_addr});
      end
      MAPPER_MODE_GXROM: begin
        prg_rom_addr = PRG_ADDR_W'({bank[5:4], prg_addr});
        chr_mem_addr = CHR_ADDR_W'({bank[1:0], chr_addr});
      end
      MAPPER_MODE_BNROM: begin
        prg_rom_addr = PRG_ADDR_W'({bank[1:0], prg_addr});
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mapper_discrete.sv
// AxROM/UxROM/CNROM/GxROM/BNROM/NROM mapper; address outputs are combinational, bank writes land 2 (or 3+) cycles later.
// Writes arriving while busy are dropped. MAPPER_DISCRETE_BUS_CONFLICT_EN enables the ROM-AND bus-conflict fetch with timeout.
module mapper_discrete
  import mapper_discrete_pkg::*;
#(
  parameter int PRG_ADDR_W     = 19,
  parameter int PRG_RAM_ADDR_W = 15,
  parameter int CHR_ADDR_W     = 18,
  parameter int BC_TIMEOUT     = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2:0]                mode_i,
  input  logic [2:0]                hdr_layout_i,
  input  logic [7:0]                prg_last_bank_i,
  input  logic                      mapper_wr_i,
  input  logic [14:0]               mapper_wr_addr_i,
  input  logic [7:0]                mapper_wr_data_i,
  input  logic [14:0]               prg_rom_addr_i,
  input  logic [12:0]               prg_ram_addr_i,
  input  logic [12:0]               chr_mem_addr_i,
  mapper_discrete_if.master         bc,
  output logic                      mapper_busy_o,
  output logic                      bc_timeout_o,
  output logic [PRG_ADDR_W-1:0]     prg_rom_addr_o,
  output logic [PRG_RAM_ADDR_W-1:0] prg_ram_addr_o,
  output logic [CHR_ADDR_W-1:0]     chr_mem_addr_o,
  output logic [2:0]                nametable_layout_o
);

  logic [2:0]  mode_r;
  logic        mode_lat_r;
  logic [7:0]  bank_r;
  wr_state_e   state_r, state_nxt;
  logic [14:0] wr_addr_r, wr_addr_nxt;
  logic [7:0]  wr_data_r, wr_data_nxt;
  logic        wr_accept;

  // mode_r resets to NROM so nothing is banked until the header mode is latched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_r     <= MAPPER_MODE_NROM;
      mode_lat_r <= 1'b0;
    end else if (!mode_lat_r) begin
      mode_r     <= mode_i;
      mode_lat_r <= 1'b1;
    end
  end

  assign wr_accept = mapper_wr_i && mode_lat_r && !is_nrom_mode(mode_r);

`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
  localparam int CNT_W = $clog2(BC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BC_TIMEOUT - 1);

  logic [CNT_W-1:0]      cnt_r, cnt_nxt;
  logic                  timeout_r;
  logic                  timeout_set;
  logic [PRG_ADDR_W-1:0] bc_prg_addr;
  logic [CHR_ADDR_W-1:0] unused_bc_chr;
  logic [2:0]            unused_bc_nt;

  // Conflict read address goes through the same banking as live CPU fetches.
  mapper_discrete_decode #(
    .PRG_ADDR_W (PRG_ADDR_W),
    .CHR_ADDR_W (CHR_ADDR_W)
  ) u_bc_decode (
    .mode             (mode_r),
    .bank             (bank_r),
    .prg_last_bank    (prg_last_bank_i),
    .hdr_layout       (hdr_layout_i),
    .prg_addr         (wr_addr_r),
    .chr_addr         (13'd0),
    .prg_rom_addr     (bc_prg_addr),
    .chr_mem_addr     (unused_bc_chr),
    .nametable_layout (unused_bc_nt)
  );

  assign bc.bc_rd_req_o  = (state_r == ST_FETCH);
  assign bc.bc_rd_addr_o = bc_prg_addr;
  assign bc_timeout_o    = timeout_r;
`else
  localparam int unused_bc_timeout = BC_TIMEOUT;
  logic unused_bc_in;
  assign unused_bc_in    = &{1'b0, bc.bc_rd_ack_i, bc.bc_rd_data_i};
  assign bc.bc_rd_req_o  = 1'b0;
  assign bc.bc_rd_addr_o = '0;
  assign bc_timeout_o    = 1'b0;
`endif

  always_comb begin
    state_nxt   = state_r;
    wr_addr_nxt = wr_addr_r;
    wr_data_nxt = wr_data_r;
`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
    cnt_nxt     = cnt_r;
    timeout_set = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (wr_accept) begin
          wr_addr_nxt = mapper_wr_addr_i;
          wr_data_nxt = mapper_wr_data_i;
`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
          cnt_nxt     = '0;
          state_nxt   = ST_FETCH;
`else
          state_nxt   = ST_COMMIT;
`endif
        end
      end
`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
      // Leaving on the cycle the count would reach BC_TIMEOUT gives BC_TIMEOUT FETCH cycles.
      ST_FETCH: begin
        if (bc.bc_rd_ack_i) begin
          wr_data_nxt = wr_data_r & bc.bc_rd_data_i;
          state_nxt   = ST_COMMIT;
        end else if (cnt_r == CNT_LAST) begin
          timeout_set = 1'b1;
          state_nxt   = ST_COMMIT;
        end else begin
          cnt_nxt = cnt_r + 1'b1;
        end
      end
`endif
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      bank_r    <= 8'h00;
`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
      cnt_r     <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt;
      wr_addr_r <= wr_addr_nxt;
      wr_data_r <= wr_data_nxt;
      if (state_r == ST_COMMIT) begin
        bank_r <= wr_data_r;
      end
`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
      cnt_r     <= cnt_nxt;
      timeout_r <= timeout_r | timeout_set;
`endif
    end
  end

  assign mapper_busy_o  = (state_r != ST_IDLE);
  assign prg_ram_addr_o = PRG_RAM_ADDR_W'(prg_ram_addr_i);

  mapper_discrete_decode #(
    .PRG_ADDR_W (PRG_ADDR_W),
    .CHR_ADDR_W (CHR_ADDR_W)
  ) u_decode (
    .mode             (mode_r),
    .bank             (bank_r),
    .prg_last_bank    (prg_last_bank_i),
    .hdr_layout       (hdr_layout_i),
    .prg_addr         (prg_rom_addr_i),
    .chr_addr         (chr_mem_addr_i),
    .prg_rom_addr     (prg_rom_addr_o),
    .chr_mem_addr     (chr_mem_addr_o),
    .nametable_layout (nametable_layout_o)
  );

endmodule

// File: tb/tb_mapper_discrete.sv
// Bench for mapper_discrete: decode vector table, randomized writes against an
// arithmetic reference model, and hand-written write/timeout/reset sequences.
module tb_mapper_discrete;
  import mapper_discrete_pkg::*;

  localparam int PW = 19;
  localparam int RW = 15;
  localparam int CW = 18;
  localparam int TO = 15;
`ifdef MAPPER_DISCRETE_BUS_CONFLICT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    mode = 3'd0;
  logic [2:0]    hdr = 3'd1;
  logic [7:0]    last_bank = 8'd0;
  logic          wr = 1'b0;
  logic [14:0]   wa = '0;
  logic [7:0]    wd = '0;
  logic [14:0]   pa = '0;
  logic [12:0]   ra = '0;
  logic [12:0]   ca = '0;
  logic          busy, tmo;
  logic [PW-1:0] prg_o;
  logic [RW-1:0] ram_o;
  logic [CW-1:0] chr_o;
  logic [2:0]    nt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mapper_discrete_if #(.PRG_ADDR_W(PW)) bc_if ();

  mapper_discrete #(
    .PRG_ADDR_W(PW), .PRG_RAM_ADDR_W(RW), .CHR_ADDR_W(CW), .BC_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .hdr_layout_i(hdr),
    .prg_last_bank_i(last_bank), .mapper_wr_i(wr), .mapper_wr_addr_i(wa),
    .mapper_wr_data_i(wd), .prg_rom_addr_i(pa), .prg_ram_addr_i(ra),
    .chr_mem_addr_i(ca), .bc(bc_if), .mapper_busy_o(busy), .bc_timeout_o(tmo),
    .prg_rom_addr_o(prg_o), .prg_ram_addr_o(ram_o), .chr_mem_addr_o(chr_o),
    .nametable_layout_o(nt_o)
  );

  // Reference model: cartridge banking expressed as bank-size arithmetic.
  function automatic int m_prg(input int m, input int bank, input int last, input int a);
    int v;
    case (m)
      0:       v = (bank % 8) * 32768 + a;
      1:       v = (a >= 16384) ? last * 16384 + (a % 16384) : (bank % 16) * 16384 + (a % 16384);
      3:       v = ((bank / 16) % 4) * 32768 + a;
      4:       v = (bank % 4) * 32768 + a;
      default: v = a;
    endcase
    return v % (1 << PW);
  endfunction

  function automatic int m_chr(input int m, input int bank, input int a);
    int v;
    v = (m == 2 || m == 3) ? (bank % 4) * 8192 + a : a;
    return v % (1 << CW);
  endfunction

  function automatic int m_nt(input int m, input int bank, input int h);
    if (m == 0) return ((bank / 16) % 2 == 1) ? int'(NT_LAYOUT_SINGLE_UPPER) : int'(NT_LAYOUT_SINGLE_LOWER);
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] m);
    @(negedge clk);
    rst = 1'b1;
    mode = m;
    wr = 1'b0;
    bc_if.bc_rd_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One CPU write; optionally acknowledges on the ack_at-th FETCH cycle.
  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input int ack_at,
                           input logic [7:0] rom, output int busy_n, output int fetch_n,
                           output logic [31:0] req_a);
    @(negedge clk);
    wr = 1'b1; wa = a; wd = d;
    @(negedge clk);
    wr = 1'b0;
    #1;
    busy_n = 0; fetch_n = 0; req_a = '0;
    for (int i = 0; i < 64 && busy; i++) begin
      busy_n++;
      if (bc_if.bc_rd_req_o) begin
        fetch_n++;
        if (fetch_n == 1) req_a = 32'(bc_if.bc_rd_addr_o);
        if (fetch_n == ack_at) begin
          bc_if.bc_rd_ack_i = 1'b1;
          bc_if.bc_rd_data_i = rom;
        end
      end
      @(negedge clk);
      bc_if.bc_rd_ack_i = 1'b0;
      bc_if.bc_rd_data_i = 8'h00;
      #1;
    end
    check("write_done_bound", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [7:0]  wdat;
    logic [7:0]  last;
    logic [2:0]  h;
    logic [14:0] prg_a;
    logic [12:0] chr_a;
    logic [31:0] e_prg;
    logic [31:0] e_chr;
    logic [2:0]  e_nt;
  } vec_t;

  vec_t vt[10];

  initial begin
    int bn, fn, m, h, lst, a, d, rom, ack_at, bank_exp, exp_req, p_a, c_a;
    bit acc;
    logic [31:0] rq;

    vt[0] = '{3'd0, 8'h15, 8'h00, 3'd1, 15'h1234, 13'h0ABC, 32'h29234, 32'h0ABC, NT_LAYOUT_SINGLE_UPPER};
    vt[1] = '{3'd0, 8'h07, 8'h00, 3'd1, 15'h7FFF, 13'h1FFF, 32'h3FFFF, 32'h1FFF, NT_LAYOUT_SINGLE_LOWER};
    vt[2] = '{3'd1, 8'h03, 8'h07, 3'd0, 15'h0010, 13'h0100, 32'h0C010, 32'h0100, 3'd0};
    vt[3] = '{3'd1, 8'h03, 8'h07, 3'd0, 15'h4010, 13'h0100, 32'h1C010, 32'h0100, 3'd0};
    vt[4] = '{3'd1, 8'h0F, 8'hFF, 3'd4, 15'h4000, 13'h0000, 32'h7C000, 32'h0000, 3'd4};
    vt[5] = '{3'd1, 8'h1F, 8'hFF, 3'd4, 15'h3FFF, 13'h0000, 32'h3FFFF, 32'h0000, 3'd4};
    vt[6] = '{3'd2, 8'h03, 8'h00, 3'd1, 15'h5555, 13'h1FFF, 32'h5555, 32'h7FFF, 3'd1};
    vt[7] = '{3'd3, 8'h31, 8'h00, 3'd0, 15'h0100, 13'h0010, 32'h18100, 32'h2010, 3'd0};
    vt[8] = '{3'd4, 8'h02, 8'h00, 3'd1, 15'h0001, 13'h0123, 32'h10001, 32'h0123, 3'd1};
    vt[9] = '{3'd6, 8'hFF, 8'h03, 3'd2, 15'h7ABC, 13'h1555, 32'h7ABC, 32'h1555, 3'd2};

    bc_if.bc_rd_ack_i = 1'b0;
    bc_if.bc_rd_data_i = 8'h00;

    // Reset state
    pa = 15'h1234; ca = 13'h0ABC; ra = 13'h1ABC;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(bc_if.bc_rd_req_o), 0);
    check("rst_timeout", 32'(tmo), 0);
    check("rst_bank", 32'(dut.bank_r), 0);
    check("rst_prg", 32'(prg_o), 32'h1234);
    check("rst_chr", 32'(chr_o), 32'h0ABC);
    check("rst_ram", 32'(ram_o), 32'h1ABC);

    // Decode vector table
    for (int i = 0; i < 10; i++) begin
      hdr = vt[i].h; last_bank = vt[i].last;
      do_reset(vt[i].m);
      cpu_write(15'h0000, vt[i].wdat, 1, 8'hFF, bn, fn, rq);
      @(negedge clk);
      pa = vt[i].prg_a; ca = vt[i].chr_a; ra = 13'(i * 613);
      #1;
      check($sformatf("vec%0d_prg", i), 32'(prg_o), vt[i].e_prg);
      check($sformatf("vec%0d_chr", i), 32'(chr_o), vt[i].e_chr);
      check($sformatf("vec%0d_ram", i), 32'(ram_o), 32'(i * 613));
      check($sformatf("vec%0d_nt", i), 32'(nt_o), 32'(vt[i].e_nt));
    end

    // Randomized writes and probes against the model
    for (int it = 0; it < 24; it++) begin
      m = $urandom_range(0, 7); h = $urandom_range(0, 7); lst = $urandom_range(0, 255);
      hdr = 3'(h); last_bank = 8'(lst);
      do_reset(3'(m));
      acc = (m < 5);
      bank_exp = 0;
      for (int w = 0; w < 2; w++) begin
        a = $urandom_range(0, 32767); d = $urandom_range(0, 255);
        rom = $urandom_range(0, 255); ack_at = $urandom_range(1, 3);
        exp_req = (BC_EN && acc) ? m_prg(m, bank_exp, lst, a) : 0;
        cpu_write(15'(a), 8'(d), ack_at, 8'(rom), bn, fn, rq);
        check("rnd_busy", 32'(bn), acc ? (BC_EN ? ack_at + 1 : 1) : 0);
        check("rnd_req_addr", rq, 32'(exp_req));
        if (acc) bank_exp = BC_EN ? (d & rom) : d;
        check("rnd_bank", 32'(dut.bank_r), 32'(bank_exp));
      end
      for (int p = 0; p < 3; p++) begin
        p_a = $urandom_range(0, 32767); c_a = $urandom_range(0, 8191);
        @(negedge clk);
        pa = 15'(p_a); ca = 13'(c_a);
        #1;
        check("rnd_prg", 32'(prg_o), 32'(m_prg(m, bank_exp, lst, p_a)));
        check("rnd_chr", 32'(chr_o), 32'(m_chr(m, bank_exp, c_a)));
        check("rnd_nt", 32'(nt_o), 32'(m_nt(m, bank_exp, h)));
      end
    end

    // Write-to-visible latency, with an ack held high from the write cycle on
    hdr = 3'd1; last_bank = 8'd0;
    do_reset(MAPPER_MODE_AXROM);
    pa = 15'h1234;
    @(negedge clk);
    wr = 1'b1; wa = 15'h0000; wd = 8'h15;
    bc_if.bc_rd_ack_i = 1'b1; bc_if.bc_rd_data_i = 8'hFF;
    @(negedge clk);
    wr = 1'b0;
    #1 check("lat_n1", 32'(prg_o), 32'h1234);
    @(negedge clk);
    #1 check("lat_n2", 32'(prg_o), BC_EN ? 32'h1234 : 32'h29234);
    @(negedge clk);
    #1 check("lat_n3", 32'(prg_o), 32'h29234);
    check("lat_nt", 32'(nt_o), 32'(NT_LAYOUT_SINGLE_UPPER));
    bc_if.bc_rd_ack_i = 1'b0;

    // Bus conflict: 0xFF ANDed with ROM byte 0x0A, ack on third FETCH cycle
    do_reset(MAPPER_MODE_UXROM);
    cpu_write(15'h0000, 8'hFF, 3, 8'h0A, bn, fn, rq);
    check("bc_busy_cycles", 32'(bn), BC_EN ? 32'd4 : 32'd1);
    check("bc_bank", 32'(dut.bank_r), BC_EN ? 32'h0A : 32'hFF);
    check("bc_req_addr", rq, 32'h0);

    // No acknowledge: timeout after TO FETCH cycles, data unmodified
    do_reset(MAPPER_MODE_AXROM);
    cpu_write(15'h0100, 8'h13, -1, 8'h00, bn, fn, rq);
    check("to_fetch_cycles", 32'(fn), BC_EN ? 32'(TO) : 32'd0);
    check("to_busy_cycles", 32'(bn), BC_EN ? 32'(TO + 1) : 32'd1);
    check("to_flag", 32'(tmo), BC_EN ? 32'd1 : 32'd0);
    check("to_bank", 32'(dut.bank_r), 32'h13);
    cpu_write(15'h0100, 8'h05, 1, 8'h0F, bn, fn, rq);
    check("to_sticky", 32'(tmo), BC_EN ? 32'd1 : 32'd0);
    check("to_bank2", 32'(dut.bank_r), 32'h05);

    // Reset mid-write: request drops and state clears asynchronously
    @(negedge clk);
    wr = 1'b1; wa = 15'h0000; wd = 8'h33;
    @(negedge clk);
    wr = 1'b0;
    #1 check("mid_busy", 32'(busy), 1);
    check("mid_req", 32'(bc_if.bc_rd_req_o), BC_EN ? 32'd1 : 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_req", 32'(bc_if.bc_rd_req_o), 0);
    check("async_busy", 32'(busy), 0);
    check("async_bank", 32'(dut.bank_r), 0);
    check("async_timeout", 32'(tmo), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("discard_bank", 32'(dut.bank_r), 0);

    // Second write while busy is dropped; stray ack outside FETCH is ignored
    do_reset(MAPPER_MODE_GXROM);
    bc_if.bc_rd_ack_i = 1'b1; bc_if.bc_rd_data_i = 8'hFF;
    @(negedge clk);
    wr = 1'b1; wa = 15'h0000; wd = 8'h11;
    @(negedge clk);
    wd = 8'h22;
    @(negedge clk);
    wr = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    bc_if.bc_rd_ack_i = 1'b0;
    #1 check("drop_idle", 32'(busy), 0);
    check("drop_bank", 32'(dut.bank_r), 32'h11);

    // Mode latched at reset release; later mode_i changes ignored
    do_reset(MAPPER_MODE_CNROM);
    mode = MAPPER_MODE_GXROM;
    cpu_write(15'h0000, 8'h31, 1, 8'hFF, bn, fn, rq);
    pa = 15'h0100; ca = 13'h0010;
    #1;
    check("latch_prg", 32'(prg_o), 32'h0100);
    check("latch_chr", 32'(chr_o), 32'h2010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
